// File: rtl/seq_divider.sv
// seq_divider: iterative signed (optionally unsigned) divider, LO=quotient, HI=remainder.
// Ports: clk, reset (async, active-low), start, dividend, divisor, [is_unsigned when SEQ_DIVIDER_DIVU_EN],
//        hi_out, lo_out, busy, done, div_zero. Macro SEQ_DIVIDER_DIVU_EN adds MIPS DIVU support.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIVIDER_DIVU_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             uns;
  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

`ifdef SEQ_DIVIDER_DIVU_EN
  assign uns = is_unsigned;
`else
  assign uns = 1'b0;
`endif

  // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign dd_mag = (!uns && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dv_mag = (!uns && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Remainder can exceed WIDTH bits for one step once shifted (unsigned
  // divisors near 2^W), so compare on WIDTH+1 bits; when ge holds the
  // difference always fits back into WIDTH bits.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});
  assign diff   = rem_sh[WIDTH-1:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            quo_d   = dd_mag;
            dvs_d   = dv_mag;
            sgnq_d  = !uns && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sgnr_d  = !uns && dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            dz_d    = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (ge) begin
          rem_d = diff;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        lo_d    = sgnq_q ? -quo_q : quo_q;
        hi_d    = sgnr_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus hand sequences for seq_divider.
// Checks results, latency, busy span, done pulse, reset abort and ignored start.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        div_zero;
`ifdef SEQ_DIVIDER_DIVU_EN
  logic        is_unsigned;
`endif

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
`ifdef SEQ_DIVIDER_DIVU_EN
    .is_unsigned(is_unsigned),
`endif
    .dividend (dividend),
    .divisor  (divisor),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] dd;
    logic [31:0] dv;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one request and waits for done (bounded at 40 edges).
  // n = edges after the sampling edge until done is seen; nb = busy cycles.
  // poke: loop index at which a 100/7 start is pulsed (-1 none).
  // rst_at: loop index at which reset is pulled low for one cycle (-1 none).
  task automatic run(input logic [31:0] dd, input logic [31:0] dv,
                     input bit imm, input int poke, input int rst_at,
                     output int n, output int nb);
    if (!imm) @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      start = (n == poke);
      if (n == poke) begin
        dividend = 32'd100;
        divisor  = 32'd7;
      end
      reset = !(n == rst_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    int n;
    int nb;
    string s;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIVIDER_DIVU_EN
    is_unsigned = 1'b0;
`endif
    tbl[0]  = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
    tbl[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    tbl[2]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};
    tbl[3]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
    tbl[4]  = '{32'd5,        32'd0,        32'hFFFFFFFD, 32'd1,        1'b1};
    tbl[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
    tbl[6]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0};
    tbl[7]  = '{32'd3,        32'd10,       32'd0,        32'd3,        1'b0};
    tbl[8]  = '{32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1'b0};
    tbl[9]  = '{32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[10] = '{32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b0};
    tbl[11] = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0};
    tbl[12] = '{32'd12345,    32'h80000000, 32'd0,        32'd12345,    1'b0};
    tbl[13] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
    tbl[14] = '{32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dz",   {31'd0, div_zero}, 32'd0);
    chk("rst_hi",   hi_out, 32'd0);
    chk("rst_lo",   lo_out, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run(tbl[i].dd, tbl[i].dv, 1'b0, -1, -1, n, nb);
      s = $sformatf("v%0d", i);
      chk({s, "_lo"},  lo_out, tbl[i].lo);
      chk({s, "_hi"},  hi_out, tbl[i].hi);
      chk({s, "_dz"},  {31'd0, div_zero}, {31'd0, tbl[i].dz});
      chk({s, "_lat"}, n,  tbl[i].dz ? 32'd0 : 32'd33);
      chk({s, "_bsy"}, nb, tbl[i].dz ? 32'd0 : 32'd33);
      @(negedge clk);
      chk({s, "_pulse"}, {31'd0, done}, 32'd0);
      chk({s, "_hold"},  lo_out, tbl[i].lo);
    end

    // start pulsed mid-operation must be ignored
    run(32'h80000000, 32'hFFFFFFFF, 1'b0, 10, -1, n, nb);
    chk("ign_lo",  lo_out, 32'h80000000);
    chk("ign_hi",  hi_out, 32'd0);
    chk("ign_lat", n, 32'd33);
    @(negedge clk);
    chk("ign_idle", {31'd0, busy}, 32'd0);

    // reset mid-operation aborts with no done
    run(32'd100, 32'd7, 1'b0, -1, 10, n, nb);
    chk("rab_nodone", n, 32'd40);
    chk("rab_busy", {31'd0, busy}, 32'd0);
    chk("rab_hi",   hi_out, 32'd0);
    chk("rab_lo",   lo_out, 32'd0);
    run(32'd100, 32'd7, 1'b0, -1, -1, n, nb);
    chk("rre_lo",  lo_out, 32'd14);
    chk("rre_hi",  hi_out, 32'd2);
    chk("rre_lat", n, 32'd33);

    // start in the very cycle done is high is accepted
    run(32'd20, 32'd3, 1'b0, -1, -1, n, nb);
    chk("b2b0_lo", lo_out, 32'd6);
    run(32'd9, 32'd4, 1'b1, -1, -1, n, nb);
    chk("b2b1_lo",  lo_out, 32'd2);
    chk("b2b1_hi",  hi_out, 32'd1);
    chk("b2b1_lat", n, 32'd33);

    // div-by-zero after a good result, then a good start clears the flag
    run(32'd1, 32'd0, 1'b0, -1, -1, n, nb);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    chk("dz_lo",   lo_out, 32'd2);
    run(32'd1, 32'd1, 1'b0, -1, -1, n, nb);
    chk("dz_clr",  {31'd0, div_zero}, 32'd0);

`ifdef SEQ_DIVIDER_DIVU_EN
    is_unsigned = 1'b1;
    run(32'hFFFFFFF9, 32'd2, 1'b0, -1, -1, n, nb);
    chk("u0_lo", lo_out, 32'h7FFFFFFC);
    chk("u0_hi", hi_out, 32'd1);
    chk("u0_lat", n, 32'd33);
    run(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, -1, -1, n, nb);
    chk("u1_lo", lo_out, 32'd1);
    chk("u1_hi", hi_out, 32'd1);
    run(32'd5, 32'd0, 1'b0, -1, -1, n, nb);
    chk("u2_dz", {31'd0, div_zero}, 32'd1);
    is_unsigned = 1'b0;
    run(32'hFFFFFFF9, 32'd2, 1'b0, -1, -1, n, nb);
    chk("u3_lo", lo_out, 32'hFFFFFFFD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
